// File: rtl/approx_err_pkg.sv
// approx_err_pkg: shared state type, default widths and saturating add for the error monitor
package approx_err_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int WIDTH_D = 16;
  localparam int CNT_W_D = 32;
  localparam int ACC_W_D = WIDTH_D + 1 + CNT_W_D;
  // w-bit saturating add carried in 64 bits; callers keep w below 64
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int w);
    logic [64:0] s;
    logic [63:0] lim;
    s = {1'b0, a} + {1'b0, b};
    lim = (64'd1 << w) - 64'd1;
    return (s > {1'b0, lim}) ? lim : s[63:0];
  endfunction
endpackage

// File: rtl/approx_err_monitor_ed_calc.sv
// ed_calc: unsigned error distance |exact - approx|
module ed_calc
  import approx_err_pkg::*;
#(
  parameter int W = WIDTH_D + 1
) (
  input  logic [W-1:0] exact,
  input  logic [W-1:0] approx,
  output logic [W-1:0] ed
);
  assign ed = (exact > approx) ? exact - approx : approx - exact;
endmodule

// File: rtl/approx_err_monitor.sv
// approx_err_monitor: per-run error statistics (sum ED, worst ED, error count) for an approximate adder
module approx_err_monitor
  import approx_err_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int CNT_W = CNT_W_D,
  parameter int ACC_W = WIDTH + 1 + CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH:0]   approx_sum,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] err_sum,
  output logic [WIDTH:0]   max_ed,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] sample_count
);
  state_t state, state_nx;
  logic [CNT_W-1:0] tgt;
  logic [WIDTH:0] s1_exact, s1_approx, ed, s2_ed;
  logic s1_v, s2_v, xfer, last, start_ok;
  assign xfer = in_valid && in_ready;
  assign last = xfer && (sample_count + CNT_W'(1) == tgt);
  assign start_ok = start && (state == IDLE || state == DONE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // DRAIN ends once stage 1 is empty: the last ED accumulates on that same edge
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = start ? RUN : state;
      RUN:        state_nx = (last || sample_count == tgt) ? DRAIN : RUN;
      DRAIN:      state_nx = s1_v ? DRAIN : DONE;
      default:    state_nx = IDLE;
    endcase
  end
  always_comb begin
    in_ready = (state == RUN) && (sample_count < tgt);
    busy = (state == RUN) || (state == DRAIN);
    done = state == DONE;
  end
  ed_calc #(.W(WIDTH + 1)) u_ed (.exact(s1_exact), .approx(s1_approx), .ed(ed));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_exact <= '0;
      s1_approx <= '0;
      s2_v <= 1'b0;
      s2_ed <= '0;
    end else begin
      s1_v <= xfer;
      s1_exact <= {1'b0, in1} + {1'b0, in2};
      s1_approx <= approx_sum;
      s2_v <= s1_v;
      s2_ed <= ed;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tgt <= '0;
      sample_count <= '0;
      err_sum <= '0;
      max_ed <= '0;
      err_count <= '0;
    end else if (start_ok) begin
      tgt <= num_samples;
      sample_count <= '0;
      err_sum <= '0;
      max_ed <= '0;
      err_count <= '0;
    end else begin
      if (xfer) sample_count <= sample_count + CNT_W'(1);
      if (s2_v) begin
        err_sum <= ACC_W'(sat_add(64'(err_sum), 64'(s2_ed), ACC_W));
        max_ed <= (s2_ed > max_ed) ? s2_ed : max_ed;
        err_count <= err_count + CNT_W'(s2_ed != '0);
      end
    end
endmodule

// File: tb/tb_approx_err_monitor.sv
// tb_approx_err_monitor: randomized and directed runs checked against a run-level statistics model
module tb_approx_err_monitor;
  localparam int W = 16, CW = 32, AW = 49, AWS = 18;
  localparam logic [63:0] MAX_L = (64'd1 << AW) - 64'd1;
  localparam logic [63:0] MAX_S = (64'd1 << AWS) - 64'd1;
  typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; logic [W:0] s; } smp_t;
  logic clk = 0, rst_n = 1, start = 0, in_valid = 0;
  logic [CW-1:0] num_samples = '0;
  logic [W-1:0] in1 = '0, in2 = '0;
  logic [W:0] approx_sum = '0;
  logic in_ready, busy, done, in_ready_s, busy_s, done_s;
  logic [AW-1:0] err_sum;
  logic [AWS-1:0] err_sum_s;
  logic [W:0] max_ed, max_ed_s;
  logic [CW-1:0] err_count, sample_count, err_count_s, sample_count_s;
  int errors = 0, checks = 0, pc = 0, done_pc = 0;
  bit done_seen = 0;
  smp_t dq[$];

  approx_err_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
    .approx_sum(approx_sum), .busy(busy), .done(done), .err_sum(err_sum),
    .max_ed(max_ed), .err_count(err_count), .sample_count(sample_count));
  approx_err_monitor #(.ACC_W(AWS)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready_s), .in1(in1), .in2(in2),
    .approx_sum(approx_sum), .busy(busy_s), .done(done_s), .err_sum(err_sum_s),
    .max_ed(max_ed_s), .err_count(err_count_s), .sample_count(sample_count_s));

  always #5 clk = ~clk;
  always @(posedge clk) pc++;
  always @(negedge clk) if (done && !done_seen) begin done_seen = 1; done_pc = pc; end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_clear(input string tag);
    check({tag, "_err_sum"}, err_sum, 0);
    check({tag, "_max_ed"}, max_ed, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_sample_count"}, sample_count, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_err_sum_s"}, err_sum_s, 0);
  endtask

  function automatic smp_t rnd_smp();
    smp_t s;
    logic [W:0] ex;
    s.a = W'($urandom);
    s.b = W'($urandom);
    ex = {1'b0, s.a} + {1'b0, s.b};
    case ($urandom % 4)
      0: s.s = ex;
      1: s.s = ex ^ 17'($urandom % 256);
      2: s.s = 17'($urandom);
      default: s.s = ex - 17'($urandom % 16);
    endcase
    return s;
  endfunction

  function automatic longint unsigned ed_of(input smp_t s);
    longint unsigned ex, ap;
    ex = 64'(s.a) + 64'(s.b);
    ap = 64'(s.s);
    return ex > ap ? ex - ap : ap - ex;
  endfunction

  // mode: 0 back-to-back, 1 valid every other cycle, 2 random valid; poke = cycle to pulse start mid-run
  task automatic run(input int n, input int extra, input int mode, input int poke);
    smp_t acc[$];
    smp_t s;
    int offers, cyc, tx_pc, st_pc, budget;
    longint unsigned sum, mx, ec, ed;
    offers = 0; cyc = 0; tx_pc = -1;
    @(posedge clk); #1 start = 1; num_samples = CW'(n);
    @(posedge clk); #1 start = 0; num_samples = $urandom; done_seen = 0; st_pc = pc;
    while (offers < n + extra && cyc < 8 * n + 40) begin
      in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom % 2);
      s = (in_valid && dq.size() > 0) ? dq.pop_front() : rnd_smp();
      {in1, in2, approx_sum} = s;
      start = (cyc == poke);
      if (start) num_samples = CW'(n + 5);
      @(negedge clk);
      check("in_ready", in_ready, acc.size() < n);
      check("sample_count_live", sample_count, acc.size());
      if (acc.size() < n) check("busy_live", busy, 1);
      if (in_valid) begin
        offers++;
        if (acc.size() < n) begin acc.push_back(s); tx_pc = pc; end
      end
      @(posedge clk); #1 cyc++;
    end
    in_valid = 0; start = 0;
    check("offers", offers, n + extra);
    budget = 0;
    while (!done_seen && budget < 20) begin @(posedge clk); #1 budget++; end
    check("done", done, 1);
    check("busy_end", busy, 0);
    if (tx_pc >= 0) check("done_latency", done_pc - tx_pc, 3);
    else check("done_latency_empty", done_pc - st_pc, 2);
    sum = 0; mx = 0; ec = 0;
    foreach (acc[i]) begin
      ed = ed_of(acc[i]);
      sum += ed;
      if (ed > mx) mx = ed;
      if (ed != 0) ec++;
    end
    check("err_sum", err_sum, sum > MAX_L ? MAX_L : sum);
    check("max_ed", max_ed, mx);
    check("err_count", err_count, ec);
    check("sample_count", sample_count, acc.size());
    check("err_sum_sat18", err_sum_s, sum > MAX_S ? MAX_S : sum);
    check("max_ed_s", max_ed_s, mx);
  endtask

  task automatic mid_reset();
    @(posedge clk); #1 start = 1; num_samples = 10;
    @(posedge clk); #1 start = 0; in_valid = 1; {in1, in2, approx_sum} = {16'h0, 16'h0, 17'h1FFFF};
    repeat (4) @(posedge clk);
    #3 rst_n = 0; in_valid = 0;
    #1 check_clear("mid_rst");
    @(negedge clk) rst_n = 1;
  endtask

  initial begin
    #1 rst_n = 0;
    #11 check_clear("rst");
    @(negedge clk) rst_n = 1;
    dq.push_back({16'h0000, 16'h0000, 17'h00000});
    dq.push_back({16'h0003, 16'h0005, 17'h00008});
    dq.push_back({16'hFFFF, 16'h0001, 17'h10000});
    run(3, 1, 0, -1);
    dq.push_back({16'd3, 16'd5, 17'h00010});
    dq.push_back({16'd100, 16'd100, 17'h000C0});
    run(2, 0, 0, -1);
    dq.push_back({16'd0, 16'd0, 17'h00005});
    dq.push_back({16'd0, 16'd0, 17'h01FFF});
    dq.push_back({16'd10, 16'd0, 17'h00003});
    run(3, 1, 1, -1);
    run(0, 1, 0, -1);
    run(6, 2, 1, -1);
    repeat (4) dq.push_back({16'd0, 16'd0, 17'h1FFFF});
    run(4, 0, 0, -1);
    run(8, 0, 0, 2);
    for (int i = 0; i < 10; i++) run(int'($urandom_range(1, 12)), int'($urandom % 3), 2, -1);
    mid_reset();
    run(5, 1, 2, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
